// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operator sequencer: opcodes, FSM state
// and seven-segment encoding (active-low {dp,g,f,e,d,c,b,a}).
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_LT  = 3'b110;
    localparam logic [2:0] OP_EQ  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CAPTURE
    } state_e;

    localparam logic [7:0] SEG_HEX [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    // A lit decimal point clears bit 7.
    function automatic logic [7:0] seg_enc(input logic [3:0] digit,
                                           input logic       dp);
        logic [7:0] s;
        s    = SEG_HEX[digit];
        s[7] = s[7] & ~dp;
        return s;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter, rising edge.
// Ports: clk, rst (async high), btn_i (raw), step_pulse_o (1-cycle pulse).
module btn_debounce #(
    parameter int DEB_CYC = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic step_pulse_o
);

    localparam int CW = $clog2(DEB_CYC + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          stable_q;
    logic          stable_d;
    logic          pulse_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Count consecutive cycles where the synced level disagrees with the
    // accepted level; any agreement restarts the count.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CW'(DEB_CYC - 1)) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            pulse_q  <= 1'b0;
        end else begin
            sync1_q  <= btn_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            pulse_q  <= stable_d & ~stable_q;
        end
    end

    assign step_pulse_o = pulse_q;

endmodule

// File: rtl/alu_op_sequencer.sv
// Lab-board ALU driver: issues operands/opcode, waits, captures, displays.
// Ports: switches/button in, ALU a/b/ctrl out, ALU res/car/of in,
// captured res/car/of, busy/done status, two active-low 7-seg digits.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int DEB_CYC    = 1000000,
    parameter int SETTLE_CYC = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw_a,
    input  logic [3:0] sw_b,
    input  logic       btn_step,
    input  logic       sweep,
    input  logic       hold_op,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_ctrl,
    input  logic [3:0] alu_res,
    input  logic       alu_car,
    input  logic       alu_of,
    output logic [3:0] res_q,
    output logic       car_q,
    output logic       of_q,
    output logic       busy,
    output logic       done,
    output logic [7:0] op_seg,
    output logic [7:0] res_seg
);

    localparam int SW = $clog2(SETTLE_CYC + 1);

    logic step_pulse;

    btn_debounce #(
        .DEB_CYC(DEB_CYC)
    ) u_deb (
        .clk         (clk),
        .rst         (rst),
        .btn_i       (btn_step),
        .step_pulse_o(step_pulse)
    );

    state_e        state_q,  state_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [3:0]    a_q,      a_d;
    logic [3:0]    b_q,      b_d;
    logic [2:0]    ctrl_q,   ctrl_d;
    logic [2:0]    opcnt_q,  opcnt_d;
    logic [2:0]    capop_q,  capop_d;
    logic          sweep_q,  sweep_d;
    logic [3:0]    res_d;
    logic          car_d;
    logic          of_d;
    logic          done_q,   done_d;

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        a_d      = a_q;
        b_d      = b_q;
        ctrl_d   = ctrl_q;
        opcnt_d  = opcnt_q;
        capop_d  = capop_q;
        sweep_d  = sweep_q;
        res_d    = res_q;
        car_d    = car_q;
        of_d     = of_q;
        done_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (step_pulse) begin
                    a_d      = sw_a;
                    b_d      = sw_b;
                    ctrl_d   = sweep ? OP_ADD : opcnt_q;
                    sweep_d  = sweep;
                    settle_d = '0;
                    state_d  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_q == SW'(SETTLE_CYC - 1)) begin
                    state_d = ST_CAPTURE;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            ST_CAPTURE: begin
                res_d   = alu_res;
                car_d   = alu_car;
                of_d    = alu_of;
                capop_d = ctrl_q;
                // A sweep chains straight into the next opcode's settle
                // window; only the last opcode ends the run.
                if (sweep_q && ctrl_q != OP_EQ) begin
                    ctrl_d   = ctrl_q + 3'd1;
                    settle_d = '0;
                    state_d  = ST_SETTLE;
                end else begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                    if (!sweep_q && !hold_op) begin
                        opcnt_d = opcnt_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            settle_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            ctrl_q   <= '0;
            opcnt_q  <= '0;
            capop_q  <= '0;
            sweep_q  <= 1'b0;
            res_q    <= '0;
            car_q    <= 1'b0;
            of_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            a_q      <= a_d;
            b_q      <= b_d;
            ctrl_q   <= ctrl_d;
            opcnt_q  <= opcnt_d;
            capop_q  <= capop_d;
            sweep_q  <= sweep_d;
            res_q    <= res_d;
            car_q    <= car_d;
            of_q     <= of_d;
            done_q   <= done_d;
        end
    end

    assign alu_a    = a_q;
    assign alu_b    = b_q;
    assign alu_ctrl = ctrl_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign op_seg   = seg_enc({1'b0, capop_q}, car_q);
    assign res_seg  = seg_enc(res_q, of_q);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural ALU, scoreboard of captures.
// Expected captures are queued at press time and popped on done.
module tb_alu_op_sequencer;
    import alu_pkg::*;

    localparam int DEB = 4;
    localparam int SET = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sw_a, sw_b;
    logic       btn_step, sweep, hold_op;
    logic [3:0] alu_a, alu_b, alu_res, res_q;
    logic [2:0] alu_ctrl;
    logic       alu_car, alu_of, car_q, of_q, busy, done;
    logic [7:0] op_seg, res_seg;

    always #5 clk = ~clk;

    alu_op_sequencer #(
        .DEB_CYC   (DEB),
        .SETTLE_CYC(SET)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sw_a    (sw_a),
        .sw_b    (sw_b),
        .btn_step(btn_step),
        .sweep   (sweep),
        .hold_op (hold_op),
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_ctrl(alu_ctrl),
        .alu_res (alu_res),
        .alu_car (alu_car),
        .alu_of  (alu_of),
        .res_q   (res_q),
        .car_q   (car_q),
        .of_q    (of_q),
        .busy    (busy),
        .done    (done),
        .op_seg  (op_seg),
        .res_seg (res_seg)
    );

    typedef struct {
        logic [3:0] res;
        logic       car;
        logic       of;
        logic [2:0] op;
    } exp_t;

    typedef struct {
        bit         to;
        int         lat;
        logic [3:0] a, b;
        logic [2:0] ctrl;
        logic [3:0] res;
        logic       car, of, busy;
        logic [7:0] rseg, oseg;
    } obs_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_op = 0;

    function automatic logic [5:0] alu_model(input logic [3:0] a,
                                             input logic [3:0] b,
                                             input logic [2:0] op);
        logic [4:0] s;
        logic [3:0] r;
        logic       c, v;
        s = '0; r = '0; c = 1'b0; v = 1'b0;
        case (op)
            OP_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[3:0]; c = s[4];
                v = (a[3] == b[3]) && (r[3] != a[3]);
            end
            OP_SUB: begin
                s = {1'b0, a} + {1'b0, ~b} + 5'd1;
                r = s[3:0]; c = s[4];
                v = (a[3] != b[3]) && (r[3] != a[3]);
            end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_NOT: r = ~a;
            OP_LT:  r = {3'b000, a < b};
            default: r = {3'b000, a == b};
        endcase
        return {r, c, v};
    endfunction

    function automatic logic [7:0] seg7(input logic [3:0] d, input logic dp);
        logic [7:0] s;
        case (d)
            4'h0: s = 8'hC0; 4'h1: s = 8'hF9; 4'h2: s = 8'hA4; 4'h3: s = 8'hB0;
            4'h4: s = 8'h99; 4'h5: s = 8'h92; 4'h6: s = 8'h82; 4'h7: s = 8'hF8;
            4'h8: s = 8'h80; 4'h9: s = 8'h90; 4'hA: s = 8'h88; 4'hB: s = 8'h83;
            4'hC: s = 8'hC6; 4'hD: s = 8'hA1; 4'hE: s = 8'h86; default: s = 8'h8E;
        endcase
        if (dp) s[7] = 1'b0;
        return s;
    endfunction

    always_comb {alu_res, alu_car, alu_of} = alu_model(alu_a, alu_b, alu_ctrl);

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    function automatic exp_t mk_exp(input logic [3:0] a, input logic [3:0] b,
                                    input logic [2:0] op);
        exp_t e;
        logic [5:0] m;
        m = alu_model(a, b, op);
        e.res = m[5:2]; e.car = m[1]; e.of = m[0]; e.op = op;
        return e;
    endfunction

    // One manual press: hold the button until done (or timeout), then
    // release and let the debouncer see the release.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                          output obs_t o);
        o = '{default: '0};
        sw_a = a; sw_b = b; btn_step = 1'b1;
        o.to = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (busy) begin o.to = 1'b0; break; end
        end
        if (!o.to) begin
            o.a = alu_a; o.b = alu_b; o.ctrl = alu_ctrl;
            o.to = 1'b1;
            for (int i = 0; i < 30; i++) begin
                tick(); o.lat++;
                if (done) begin o.to = 1'b0; break; end
            end
            o.res = res_q; o.car = car_q; o.of = of_q; o.busy = busy;
            o.rseg = res_seg; o.oseg = op_seg;
        end
        btn_step = 1'b0;
        tick(DEB + 6);
    endtask

    task automatic test_reset();
        rst = 1'b1; sw_a = '0; sw_b = '0; btn_step = 1'b0;
        sweep = 1'b0; hold_op = 1'b0;
        tick(3);
        checks++;
        if ({alu_a, alu_b, alu_ctrl, res_q, car_q, of_q, busy, done} !== 19'h0) begin
            errors++;
            $display("FAIL reset_outs got %h %h %h %h %b %b %b %b exp all 0",
                     alu_a, alu_b, alu_ctrl, res_q, car_q, of_q, busy, done);
        end
        checks++;
        if ({op_seg, res_seg} !== 16'hC0C0) begin
            errors++;
            $display("FAIL reset_segs got %h %h exp c0 c0", op_seg, res_seg);
        end
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_manual_add();
        obs_t o;
        exp_t e;
        sbq.push_back(mk_exp(4'd3, 4'd4, 3'(exp_op)));
        run_op(4'd3, 4'd4, o);
        e = sbq.pop_front();
        exp_op = (exp_op + 1) % 8;
        checks++;
        if (o.to) begin errors++; $display("FAIL add_timeout got timeout exp done"); end
        checks++;
        if ({o.a, o.b, o.ctrl} !== {4'd3, 4'd4, 3'd0}) begin
            errors++;
            $display("FAIL add_issue got %h %h %h exp 3 4 0", o.a, o.b, o.ctrl);
        end
        checks++;
        if (o.lat != SET + 1) begin
            errors++; $display("FAIL add_latency got %0d exp %0d", o.lat, SET + 1);
        end
        checks++;
        if ({o.res, o.car, o.of, o.busy, o.rseg, o.oseg} !==
            {e.res, e.car, e.of, 1'b0, 8'hF8, 8'hC0}) begin
            errors++;
            $display("FAIL add_result got %h %b %b busy %b %h %h exp %h %b %b busy 0 f8 c0",
                     o.res, o.car, o.of, o.busy, o.rseg, o.oseg, e.res, e.car, e.of);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        seen = 1'b0;
        sw_a = 4'd9; sw_b = 4'd2; btn_step = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (busy) begin seen = 1'b1; break; end
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL rstmid_issue got no busy exp busy"); end
        tick();
        rst = 1'b1; btn_step = 1'b0;
        #1;
        checks++;
        if ({alu_a, alu_b, alu_ctrl, res_q, car_q, of_q, busy, done} !== 19'h0) begin
            errors++;
            $display("FAIL rstmid_outs got %h %h %h %h %b %b %b %b exp all 0",
                     alu_a, alu_b, alu_ctrl, res_q, car_q, of_q, busy, done);
        end
        checks++;
        if ({op_seg, res_seg} !== 16'hC0C0) begin
            errors++;
            $display("FAIL rstmid_segs got %h %h exp c0 c0", op_seg, res_seg);
        end
        tick(2);
        rst = 1'b0;
        exp_op = 0;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done || busy) seen = 1'b1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL rstmid_nodone got activity exp none"); end
    endtask

    task automatic test_overflow();
        obs_t o;
        exp_t e;
        sbq.push_back(mk_exp(4'd7, 4'd1, 3'(exp_op)));
        run_op(4'd7, 4'd1, o);
        e = sbq.pop_front();
        exp_op = (exp_op + 1) % 8;
        checks++;
        if (o.to || o.ctrl !== 3'd0) begin
            errors++; $display("FAIL ovf_issue got to=%b op %h exp op 0", o.to, o.ctrl);
        end
        checks++;
        if ({o.res, o.car, o.of, o.rseg, o.oseg} !==
            {e.res, e.car, e.of, seg7(e.res, e.of), seg7({1'b0, e.op}, e.car)} ||
            o.rseg !== 8'h00) begin
            errors++;
            $display("FAIL ovf_result got %h %b %b %h %h exp %h %b %b 00",
                     o.res, o.car, o.of, o.rseg, o.oseg, e.res, e.car, e.of);
        end
    endtask

    task automatic test_bounce();
        obs_t o;
        exp_t e;
        bit   act;
        act = 1'b0;
        sw_a = 4'hA; sw_b = 4'hB;
        for (int k = 0; k < 5; k++) begin
            btn_step = 1'b1;
            for (int i = 0; i < 2; i++) begin tick(); if (busy) act = 1'b1; end
            btn_step = 1'b0;
            for (int i = 0; i < 3; i++) begin tick(); if (busy) act = 1'b1; end
        end
        tick(DEB + 4);
        checks++;
        if (act || {alu_a, alu_b} !== {4'd7, 4'd1}) begin
            errors++;
            $display("FAIL bounce_ignored got busy=%b a %h b %h exp busy 0 a 7 b 1",
                     act, alu_a, alu_b);
        end
        sbq.push_back(mk_exp(4'd5, 4'd6, 3'(exp_op)));
        run_op(4'd5, 4'd6, o);
        e = sbq.pop_front();
        exp_op = (exp_op + 1) % 8;
        checks++;
        if (o.to || {o.a, o.b, o.ctrl} !== {4'd5, 4'd6, e.op}) begin
            errors++;
            $display("FAIL bounce_issue got to=%b %h %h %h exp 5 6 %h",
                     o.to, o.a, o.b, o.ctrl, e.op);
        end
        checks++;
        if ({o.res, o.car, o.of, o.rseg} !== {e.res, e.car, e.of, seg7(e.res, e.of)}) begin
            errors++;
            $display("FAIL bounce_result got %h %b %b %h exp %h %b %b",
                     o.res, o.car, o.of, o.rseg, e.res, e.car, e.of);
        end
        act = 1'b0;
        for (int i = 0; i < 20; i++) begin tick(); if (busy) act = 1'b1; end
        checks++;
        if (act) begin errors++; $display("FAIL bounce_single got second op exp one"); end
    endtask

    task automatic test_sweep();
        exp_t e;
        bit   seen, ok, act;
        int   c;
        seen = 1'b0;
        sw_a = 4'd2; sw_b = 4'd3; sweep = 1'b1;
        sbq.push_back(mk_exp(4'd2, 4'd3, OP_EQ));
        btn_step = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (busy) begin seen = 1'b1; break; end
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL sweep_start got no busy exp busy"); end
        c = 0;
        for (int op = 0; op < 8; op++) begin
            ok = 1'b1;
            for (int j = 0; j <= SET; j++) begin
                if (c > 0) tick();
                if (c == 1) btn_step = 1'b0;
                if (c == 2) sw_a = 4'hF;
                if (c == 10) btn_step = 1'b1;
                if (alu_ctrl !== 3'(op) || !busy || done || alu_a !== 4'd2)
                    ok = 1'b0;
                c++;
            end
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL sweep_op%0d got ctrl %h busy %b done %b a %h exp ctrl %0d busy 1 a 2",
                         op, alu_ctrl, busy, done, alu_a, op);
            end
        end
        tick();
        e = sbq.pop_front();
        checks++;
        if ({done, busy, res_q, car_q, of_q, op_seg, res_seg} !==
            {1'b1, 1'b0, e.res, e.car, e.of, seg7({1'b0, e.op}, e.car), seg7(e.res, e.of)} ||
            op_seg !== 8'hF8) begin
            errors++;
            $display("FAIL sweep_done got done %b busy %b %h %b %b %h %h exp done 1 busy 0 %h %b %b f8",
                     done, busy, res_q, car_q, of_q, op_seg, res_seg, e.res, e.car, e.of);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL sweep_pulse got done %b exp 0", done); end
        tick(3);
        btn_step = 1'b0; sweep = 1'b0;
        act = 1'b0;
        for (int i = 0; i < 20; i++) begin tick(); if (busy) act = 1'b1; end
        checks++;
        if (act) begin errors++; $display("FAIL sweep_press_ignored got busy exp idle"); end
    endtask

    task automatic test_wrap_hold();
        obs_t o;
        exp_t e;
        // ops 2..7 step the counter, the next wraps to 0; then two held
        // presses must both reuse op 0, and releasing hold advances again.
        for (int k = 0; k < 10; k++) begin
            hold_op = (k == 6 || k == 7);
            sbq.push_back(mk_exp(4'(k + 1), 4'd2, 3'(exp_op)));
            run_op(4'(k + 1), 4'd2, o);
            e = sbq.pop_front();
            if (!hold_op) exp_op = (exp_op + 1) % 8;
            checks++;
            if (o.to || {o.a, o.b, o.ctrl} !== {4'(k + 1), 4'd2, e.op}) begin
                errors++;
                $display("FAIL wrap_issue%0d got to=%b %h %h op %h exp %h 2 op %h",
                         k, o.to, o.a, o.b, o.ctrl, 4'(k + 1), e.op);
            end
            checks++;
            if ({o.res, o.car, o.of, o.oseg} !==
                {e.res, e.car, e.of, seg7({1'b0, e.op}, e.car)}) begin
                errors++;
                $display("FAIL wrap_result%0d got %h %b %b %h exp %h %b %b %h",
                         k, o.res, o.car, o.of, o.oseg, e.res, e.car, e.of,
                         seg7({1'b0, e.op}, e.car));
            end
        end
        hold_op = 1'b0;
    endtask

    initial begin
        test_reset();
        test_manual_add();
        test_reset_mid();
        test_overflow();
        test_bounce();
        test_sweep();
        test_wrap_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
